// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared fetch states, constants and opcode defines
package instr_fetch_unit_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_t;

  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// rtl/instr_fetch_unit_fetch_fifo.sv - synchronous {pc, instr} buffer with flush
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // A pop in the flush cycle still completes; the flush then empties the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (i_pop)  r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - credit-limited instruction fetch with redirect flush
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t r_state, w_state_next;
  logic [31:0]  r_pc, w_pc_next;
  logic [31:0]  r_rsp_pc, w_rsp_pc_next;
  logic [CW-1:0] r_out, w_out_next;
  logic [CW-1:0] r_stale, w_stale_next;
  logic [CW:0]   w_used;
  logic [CW-1:0] w_count;
  logic [63:0]   w_head;
  logic          w_empty, w_pop, w_gnt, w_rv, w_push;

  assign inst_valid = !w_empty;
  assign w_pop      = inst_valid & inst_ready;
  assign w_used     = {1'b0, r_out} + {1'b0, w_count} - (CW+1)'(w_pop);
  assign imem_req   = !rst && (r_state == ST_RUN) && (w_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr  = r_pc;
  assign w_gnt      = imem_req & imem_gnt;
  // A response with nothing outstanding is a protocol error and is dropped.
  assign w_rv       = imem_rvalid && (r_out != '0);
  assign w_push     = w_rv && (r_state == ST_RUN) && !redirect_valid;
  assign w_out_next = r_out + CW'(w_gnt) - CW'(w_rv);

  // Responses are in order, so the pc of the next kept response just counts up.
  assign w_pc_next     = redirect_valid ? align_pc(redirect_pc) : (w_gnt ? r_pc + PC_STEP : r_pc);
  assign w_rsp_pc_next = redirect_valid ? align_pc(redirect_pc) : (w_push ? r_rsp_pc + PC_STEP : r_rsp_pc);

  always_comb begin
    w_state_next = r_state;
    w_stale_next = r_stale;
    case (r_state)
      ST_RUN: begin
        if (redirect_valid) begin
          w_stale_next = w_out_next;
          w_state_next = (w_out_next != '0) ? ST_FLUSH : ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (w_rv && (r_stale != '0)) w_stale_next = r_stale - 1'b1;
        if (redirect_valid) begin
          w_stale_next = w_out_next;
        end else if (w_stale_next == '0) begin
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_out    <= '0;
      r_stale  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_rsp_pc <= w_rsp_pc_next;
      r_out    <= w_out_next;
      r_stale  <= w_stale_next;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_wdata ({r_rsp_pc, imem_rdata}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign inst_pc   = w_empty ? 32'h0 : w_head[63:32];
  assign inst_data = w_empty ? 32'h0 : w_head[31:0];

endmodule
